// File: rtl/config_pkg.sv
// Shared scalar types and per-peripheral CSR constants.
// Also hosts the vCSR field-mask helper used by csr_register.
package config_pkg;
   typedef logic [31:0] word;
   typedef logic [4:0]  r;
   typedef logic [11:0] CsrAddrT;
   typedef logic [4:0]  vcsr_width_t;
   typedef logic [4:0]  vcsr_offset_t;

   localparam int      TimerTWidth = 32;
   localparam CsrAddrT TimerAddr   = 12'h7C0;

   // width encodes (bits - 1), so 31 must yield an all-ones mask
   function automatic word field_mask(vcsr_width_t w);
      logic [32:0] m;
      m = (33'd1 << (6'(w) + 6'd1)) - 33'd1;
      return m[31:0];
   endfunction
endpackage

// File: rtl/decoder_pkg.sv
// Zicsr funct3 encodings shared by the decoder and CSR blocks.
package decoder_pkg;
   typedef enum logic [2:0] {
      CSR_NONE = 3'b000,
      CSR_RW   = 3'b001,
      CSR_RS   = 3'b010,
      CSR_RC   = 3'b011,
      CSR_RSVD = 3'b100,
      CSR_RWI  = 3'b101,
      CSR_RSI  = 3'b110,
      CSR_RCI  = 3'b111
   } csr_op_t;
endpackage

// File: rtl/csr_alu.sv
// Zicsr read-modify-write datapath: write, set or clear bits.
// Shared by the full-register and vCSR field paths.
module csr_alu
   import config_pkg::*;
   import decoder_pkg::*;
(
   input  csr_op_t op,
   input  word     old_val,
   input  word     src,
   output word     new_val
);
   always_comb begin
      new_val = old_val;
      unique case (op)
         CSR_RW, CSR_RWI: new_val = src;
         CSR_RS, CSR_RSI: new_val = old_val | src;
         CSR_RC, CSR_RCI: new_val = old_val & ~src;
         default:         new_val = old_val;
      endcase
   end
endmodule

// File: rtl/csr_register.sv
// Single CSR with direct and vCSR bit-field access plus a
// hardware write port for the owning peripheral.
module csr_register
   import config_pkg::*;
   import decoder_pkg::*;
#(
   parameter int                  CsrWidth   = 32,
   parameter CsrAddrT             Addr       = 12'h000,
   parameter logic [CsrWidth-1:0] ResetValue = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                csr_enable,
   input  CsrAddrT             csr_addr,
   input  csr_op_t             csr_op,
   input  r                    rs1_zimm,
   input  word                 rs1_data,
   input  vcsr_width_t         vcsr_width,
   input  vcsr_offset_t        vcsr_offset,
   input  CsrAddrT             vcsr_addr,
   input  logic [CsrWidth-1:0] ext_data,
   input  logic                ext_write_enable,
   output word                 direct_out,
   output word                 out,
   output logic [CsrWidth-1:0] data
);
   logic [CsrWidth-1:0] q;
   word  cur, src, fmask;
   word  f_old, f_src, f_new;
   word  d_new, v_new, sw_next;
   logic direct_hit, vcsr_hit, sw_we;

   assign cur = word'(q);
   assign src = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;

   assign direct_hit = csr_enable && (csr_addr == Addr);
   assign vcsr_hit   = csr_enable && (csr_addr != Addr)
                       && (vcsr_addr == Addr);
   assign sw_we      = (direct_hit || vcsr_hit)
                       && (csr_op[1:0] != 2'b00);

   // bits of cur above CsrWidth are zero, so they read as 0
   assign fmask = field_mask(vcsr_width);
   assign f_old = (cur >> vcsr_offset) & fmask;
   assign f_src = src & fmask;

   csr_alu u_alu_reg (
      .op      (csr_op),
      .old_val (cur),
      .src     (src),
      .new_val (d_new)
   );

   csr_alu u_alu_fld (
      .op      (csr_op),
      .old_val (f_old),
      .src     (f_src),
      .new_val (f_new)
   );

   assign v_new = (cur & ~(fmask << vcsr_offset))
                | ((f_new & fmask) << vcsr_offset);
   assign sw_next = direct_hit ? d_new : v_new;

   // software access beats the hardware port in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= ResetValue;
      end else if (sw_we) begin
         q <= sw_next[CsrWidth-1:0];
      end else if (ext_write_enable && !(direct_hit || vcsr_hit)) begin
         q <= ext_data;
      end
   end

   always_comb begin
      out = '0;
      if (direct_hit) begin
         out = cur;
      end else if (vcsr_hit) begin
         out = f_old;
      end
   end

   assign direct_out = cur;
   assign data       = q;
endmodule

// File: tb/tb_csr_register.sv
// Randomised bench for csr_register (32- and 8-bit instances)
// against a bit-level behavioural model, plus directed cases.
module tb_csr_register;
   import config_pkg::*;
   import decoder_pkg::*;

   localparam CsrAddrT A = 12'h300;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         csr_enable = 1'b0;
   CsrAddrT      csr_addr = '0;
   CsrAddrT      vcsr_addr = '0;
   logic [2:0]   op = '0;
   r             zimm = '0;
   word          rs1 = '0;
   vcsr_width_t  vw = '0;
   vcsr_offset_t vo = '0;
   word          ext = '0;
   logic         ext_we = 1'b0;

   word        out32, dout32, data32;
   word        out8, dout8;
   logic [7:0] data8;
   word        m32, m8, o;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   csr_register #(
      .CsrWidth(32), .Addr(A), .ResetValue(32'h5)
   ) u32 (
      .clk(clk), .reset(reset), .csr_enable(csr_enable),
      .csr_addr(csr_addr), .csr_op(csr_op_t'(op)),
      .rs1_zimm(zimm), .rs1_data(rs1),
      .vcsr_width(vw), .vcsr_offset(vo), .vcsr_addr(vcsr_addr),
      .ext_data(ext), .ext_write_enable(ext_we),
      .direct_out(dout32), .out(out32), .data(data32)
   );

   csr_register #(
      .CsrWidth(8), .Addr(A), .ResetValue(8'h5)
   ) u8 (
      .clk(clk), .reset(reset), .csr_enable(csr_enable),
      .csr_addr(csr_addr), .csr_op(csr_op_t'(op)),
      .rs1_zimm(zimm), .rs1_data(rs1),
      .vcsr_width(vw), .vcsr_offset(vo), .vcsr_addr(vcsr_addr),
      .ext_data(ext[7:0]), .ext_write_enable(ext_we),
      .direct_out(dout8), .out(out8), .data(data8)
   );

   task automatic check(string name, word act, word exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic word lowmask(int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic word m_src();
      return op[2] ? {27'd0, zimm} : rs1;
   endfunction

   function automatic logic m_bit(logic old_b, logic s_b);
      case (op[1:0])
         2'b01:   return s_b;
         2'b10:   return old_b | s_b;
         2'b11:   return old_b & ~s_b;
         default: return old_b;
      endcase
   endfunction

   function automatic word m_out(word st, int w);
      word res;
      int  p;
      res = '0;
      if (!csr_enable) return '0;
      if (csr_addr == A) return st;
      if (vcsr_addr != A) return '0;
      for (int i = 0; i <= int'(vw); i++) begin
         p = int'(vo) + i;
         if (p < w) res[i] = st[p];
      end
      return res;
   endfunction

   function automatic word m_next(word st, int w);
      word s, n;
      int  p;
      s = m_src();
      n = st;
      if (csr_enable && csr_addr == A) begin
         if (op[1:0] == 2'b00) return st;
         for (int i = 0; i < w; i++) n[i] = m_bit(st[i], s[i]);
         return n & lowmask(w);
      end
      if (csr_enable && vcsr_addr == A) begin
         if (op[1:0] == 2'b00) return st;
         for (int i = 0; i <= int'(vw); i++) begin
            p = int'(vo) + i;
            if (p < w) n[p] = m_bit(st[p], s[i]);
         end
         return n;
      end
      if (ext_we) return ext & lowmask(w);
      return st;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m32 <= 32'h5;
         m8  <= 32'h5;
      end else begin
         m32 <= m_next(m32, 32);
         m8  <= m_next(m8, 8);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("out32", out32, m_out(m32, 32));
         check("dout32", dout32, m32);
         check("data32", data32, m32);
         check("out8", out8, m_out(m8, 8));
         check("dout8", dout8, m8);
         check("data8", {24'd0, data8}, m8);
      end
   end

   task automatic issue(logic [2:0] o_i, CsrAddrT a, word d,
                        r z, output word rd);
      csr_enable = 1'b1;
      op = o_i;
      csr_addr = a;
      rs1 = d;
      zimm = z;
      @(negedge clk);
      rd = out32;
      @(posedge clk);
      #1;
      csr_enable = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      check("rst_async32", data32, 32'h5);
      check("rst_async8", {24'd0, data8}, 32'h5);
      @(posedge clk);
      #1 reset = 1'b0;
      chk_on = 1'b1;

      issue(3'b001, A, 32'hDEAD_BEEF, 5'd0, o);
      check("rw_old_out", o, 32'h5);
      check("rw_new", data32, 32'hDEAD_BEEF);
      check("rw_new8", {24'd0, data8}, 32'hEF);

      issue(3'b001, A, 32'hF0, 5'd0, o);
      issue(3'b010, A, 32'h0F, 5'd0, o);
      check("rs", data32, 32'hFF);
      issue(3'b011, A, 32'h3C, 5'd0, o);
      check("rc", data32, 32'hC3);
      issue(3'b110, A, 32'h0, 5'd0, o);
      check("rsi_zero", data32, 32'hC3);

      issue(3'b101, A, 32'h0, 5'h1F, o);
      check("rwi8", {24'd0, data8}, 32'h1F);
      issue(3'b001, A, 32'h1234, 5'd0, o);
      check("trunc8", {24'd0, data8}, 32'h34);
      check("trunc8_dout", dout8, 32'h34);

      issue(3'b001, 12'h301, 32'h999, 5'd0, o);
      check("miss_out", o, 32'h0);
      check("miss_keep", data32, 32'h1234);

      issue(3'b001, A, 32'hAABB_CCDD, 5'd0, o);
      vcsr_addr = A;
      vo = 5'd8;
      vw = 5'd7;
      issue(3'b000, 12'h123, 32'h0, 5'd0, o);
      check("vcsr_read", o, 32'hCC);
      check("vcsr_nowr", data32, 32'hAABB_CCDD);
      issue(3'b101, 12'h123, 32'h0, 5'h11, o);
      check("vcsr_rwi", data32, 32'hAABB_11DD);
      issue(3'b011, 12'h123, 32'h1, 5'd0, o);
      check("vcsr_rc", data32, 32'hAABB_10DD);
      vcsr_addr = '0;

      ext = 32'h42;
      ext_we = 1'b1;
      @(posedge clk);
      #1 ext_we = 1'b0;
      check("ext_wr", data32, 32'h42);

      ext_we = 1'b1;
      issue(3'b001, A, 32'h7, 5'd0, o);
      ext_we = 1'b0;
      check("sw_wins", data32, 32'h7);

      csr_enable = 1'b1;
      op = 3'b001;
      csr_addr = A;
      rs1 = 32'h55;
      #3 reset = 1'b1;
      #1;
      check("mid_reset", data32, 32'h5);
      @(posedge clk);
      #1;
      reset = 1'b0;
      csr_enable = 1'b0;
      check("mid_reset_hold", data32, 32'h5);

      for (int n = 0; n < 3000; n++) begin
         csr_enable = ($urandom_range(0, 3) != 0);
         op = 3'($urandom);
         case ($urandom_range(0, 2))
            0:       csr_addr = A;
            1:       csr_addr = 12'h301;
            default: csr_addr = 12'($urandom);
         endcase
         case ($urandom_range(0, 2))
            0:       vcsr_addr = A;
            1:       vcsr_addr = 12'h301;
            default: vcsr_addr = 12'($urandom);
         endcase
         rs1 = $urandom;
         zimm = 5'($urandom);
         vw = 5'($urandom);
         vo = 5'($urandom);
         ext = $urandom;
         ext_we = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 199) == 0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      csr_enable = 1'b0;
      ext_we = 1'b0;
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
